count_checker: RTL and testbench
================================

Name: count_checker

Overview:
- Passive observer on the counter bank's count outputs (count0..count2, 8 bit each); checks every sample against the legal step rule.
- Each violating cycle is queued as an event record in a small FIFO; the Verilua side drains it through a valid/ready pop interface.
- Sits beside the DUT in the testbench top, clocked by the same clk. It is the consumer end of the counter outputs.

Parameters:
- WIDTH, 8, bit width of each observed counter
- NUM_CNT, 3, number of observed counters
- DEPTH, 8, event FIFO entries; power of two, at least 2
- TS_W, 16, timestamp width

Ports:
- clk  input  1  sampling clock
- reset  input  1  asynchronous, active-low reset
- sample_en  input  1  sample count_in this cycle
- clear  input  1  synchronous: disarm, flush FIFO, zero stats
- count_in  input  NUM_CNT*WIDTH  packed counters, counter i at [i*WIDTH +: WIDTH]
- evt_valid  output  1  FIFO head valid
- evt_ready  input  1  consumer pops head when evt_valid & evt_ready
- evt_mask  output  NUM_CNT  per-counter violation bits of head
- evt_snap  output  NUM_CNT*WIDTH  observed counts of head
- evt_time  output  TS_W  timestamp of head
- armed  output  1  reference values captured
- overflow  output  1  sticky: an event was dropped
- err_total  output  16  saturating count of violating samples

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; FIFO empty; evt_valid=0; evt_mask, evt_snap and evt_time read 0; armed=0; overflow=0; err_total=0; timestamp=0.
- Timestamp: free-running TS_W counter, +1 every cycle after reset, wraps modulo 2^TS_W. clear zeroes it.
- FSM states: IDLE, CHECK.
  - IDLE with sample_en: capture count_in as prev[i]; go to CHECK; armed=1 from the next cycle. No check is made on this sample.
  - CHECK with sample_en: for each i, legal if count_in[i]==prev[i] (hold) or count_in[i]==prev[i]+1 mod 2^WIDTH (255->0 is legal). Otherwise mask[i]=1. prev is then updated to count_in regardless of result.
  - sample_en=0: no check, no prev update.
- Violating sample (mask!=0):
  - Push {mask, count_in, timestamp} in the same cycle.
  - err_total increments, saturating at 0xFFFF.
  - Entry is visible on evt_* one cycle after the sampling edge (registered FIFO, latency 1).
- Multiple counters failing in the same cycle: one entry, multiple mask bits set.
- Full FIFO with no pop that cycle: entry dropped; overflow=1 (sticky until clear or reset); err_total still increments.
- Full FIFO with pop and push in the same cycle: both happen; no drop.
- Pop: evt_valid & evt_ready advances the head. evt_ready while empty has no effect. evt_* hold stable while evt_valid=1 and evt_ready=0.
- clear (synchronous):
  - next state IDLE, armed=0;
  - FIFO flushed (evt_valid=0 next cycle);
  - overflow=0, err_total=0, timestamp=0;
  - clear wins over a simultaneous sample or push.
- Reset mid-operation: all state lost immediately; the next sample re-arms from IDLE.
- FIFO: DEPTH entries, log2(DEPTH)+1-bit read/write pointers; full when the MSBs differ and the low bits are equal.

Decomposition:
- Package count_checker_pkg:
  - event-record struct typedef (mask, snap, time);
  - FSM state enum;
  - ERR_TOTAL_W=16 constant;
  - legal-step function (hold-or-+1 modulo 2^WIDTH).
- Sub-module: count_checker_fifo, a generic synchronous FIFO with push/pop/full/empty on the packed record. The FSM and check logic stay in the top.

Test Plan:
- Reset then sample 0,1,2,2,3 on all counters -> armed=1 after first sample; evt_valid stays 0; err_total=0.
- Arm at count0=254, then 255, then 0 -> no event (wrap legal).
- Arm at {c2,c1,c0}={5,5,5}, then {5,9,7} -> one event: evt_mask=3'b011, evt_snap=={5,9,7}, err_total=1, evt_valid high one cycle after the sample.
- evt_ready=0; force 9 consecutive violating samples -> 8 entries queued, overflow=1, err_total=9. Popping all 8 returns timestamps in increasing order.
- FIFO full; same cycle: violation plus pop -> no drop, overflow stays 0, occupancy stays 8.
- Mid-run with 3 queued entries, pulse clear with a simultaneous violation -> next cycle evt_valid=0, armed=0, err_total=0; after reset=0 pulse, all outputs read reset values.

Source files
------------

// File: rtl/count_checker_pkg.sv
// Shared types and helpers for the counter-bank step checker.
// Default widths here describe the record layout seen by event consumers.
package count_checker_pkg;

  localparam int CC_WIDTH    = 8;
  localparam int CC_NUM_CNT  = 3;
  localparam int CC_TS_W     = 16;
  localparam int ERR_TOTAL_W = 16;

  typedef struct packed {
    logic [CC_NUM_CNT-1:0]          mask;
    logic [CC_NUM_CNT*CC_WIDTH-1:0] snap;
    logic [CC_TS_W-1:0]             ts;
  } evt_rec_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CHECK = 1'b1
  } cc_state_t;

  // A counter may hold or advance by one, wrapping modulo 2^w.
  function automatic logic legal_step(input logic [31:0] prev,
                                      input logic [31:0] cur,
                                      input int          w);
    logic [31:0] msk;
    logic [31:0] inc;
    msk = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    inc = (prev + 32'd1) & msk;
    return (cur == prev) || (cur == inc);
  endfunction

endpackage

// File: rtl/count_checker_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head is read combinationally
// so a pushed entry is visible the cycle after its write edge.
module count_checker_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/count_checker.sv
// Passive step-rule checker for a bank of counters; violations are queued
// as {mask, snapshot, timestamp} records drained over valid/ready.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | no reference yet; next sample only captures prev values
//   ST_CHECK | armed; every sample is compared against prev, then stored
module count_checker
  import count_checker_pkg::*;
#(
  parameter int WIDTH   = CC_WIDTH,
  parameter int NUM_CNT = CC_NUM_CNT,
  parameter int DEPTH   = 8,
  parameter int TS_W    = CC_TS_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_en,
  input  logic                     clear,
  input  logic [NUM_CNT*WIDTH-1:0] count_in,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [NUM_CNT-1:0]       evt_mask,
  output logic [NUM_CNT*WIDTH-1:0] evt_snap,
  output logic [TS_W-1:0]          evt_time,
  output logic                     armed,
  output logic                     overflow,
  output logic [ERR_TOTAL_W-1:0]   err_total
);

  typedef struct packed {
    logic [NUM_CNT-1:0]       mask;
    logic [NUM_CNT*WIDTH-1:0] snap;
    logic [TS_W-1:0]          ts;
  } rec_t;

  cc_state_t            state_q;
  cc_state_t            state_d;
  logic [WIDTH-1:0]     prev_q [NUM_CNT];
  logic [TS_W-1:0]      ts_q;
  logic [ERR_TOTAL_W-1:0] err_q;
  logic                 ovf_q;
  logic [NUM_CNT-1:0]   mask;
  logic                 capture;
  logic                 violation;
  logic                 pop;
  logic                 drop;
  logic                 fifo_full;
  logic                 fifo_empty;
  rec_t                 push_rec;
  rec_t                 head_rec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask    = '0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample_en) begin
          state_d = ST_CHECK;
          capture = 1'b1;
        end
      end
      ST_CHECK: begin
        if (sample_en) begin
          capture = 1'b1;
          for (int i = 0; i < NUM_CNT; i++) begin
            mask[i] = !legal_step(32'(prev_q[i]), 32'(count_in[i*WIDTH +: WIDTH]), WIDTH);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear) begin
      state_d = ST_IDLE;
      capture = 1'b0;
    end
  end

  // clear outranks any violation seen in the same cycle
  assign violation = (|mask) && !clear;
  assign pop       = evt_valid && evt_ready;
  assign drop      = violation && fifo_full && !pop;

  assign push_rec.mask = mask;
  assign push_rec.snap = count_in;
  assign push_rec.ts   = ts_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CNT; i++) prev_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_CNT; i++) prev_q[i] <= count_in[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_q  <= '0;
      err_q <= '0;
      ovf_q <= 1'b0;
    end else if (clear) begin
      ts_q  <= '0;
      err_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (violation && (err_q != '1)) err_q <= err_q + 1'b1;
      if (drop) ovf_q <= 1'b1;
    end
  end

  count_checker_fifo #(
    .DATA_W ($bits(rec_t)),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (clear),
    .push  (violation),
    .pop   (pop),
    .din   (push_rec),
    .dout  (head_rec),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  // Stale storage behind an empty FIFO never reaches the outputs.
  assign evt_mask  = evt_valid ? head_rec.mask : '0;
  assign evt_snap  = evt_valid ? head_rec.snap : '0;
  assign evt_time  = evt_valid ? head_rec.ts   : '0;
  assign armed     = (state_q == ST_CHECK);
  assign overflow  = ovf_q;
  assign err_total = err_q;

endmodule

// File: tb/tb_count_checker.sv
// Self-checking bench for count_checker: directed scenarios plus random
// traffic compared every cycle against a queue-based reference model.
module tb_count_checker;
  import count_checker_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_en;
  logic        clear;
  logic [23:0] count_in;
  logic        evt_valid;
  logic        evt_ready;
  logic [2:0]  evt_mask;
  logic [23:0] evt_snap;
  logic [15:0] evt_time;
  logic        armed;
  logic        overflow;
  logic [15:0] err_total;

  int checks = 0;
  int errors = 0;

  evt_rec_t   mq[$];
  bit         m_armed;
  logic [7:0] m_prev [3];
  int         m_ts;
  int         m_err;
  bit         m_ovf;

  count_checker #(.WIDTH(8), .NUM_CNT(3), .DEPTH(DEPTH), .TS_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .clear     (clear),
    .count_in  (count_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_mask  (evt_mask),
    .evt_snap  (evt_snap),
    .evt_time  (evt_time),
    .armed     (armed),
    .overflow  (overflow),
    .err_total (err_total)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_armed = 0;
    m_ts    = 0;
    m_err   = 0;
    m_ovf   = 0;
    for (int i = 0; i < 3; i++) m_prev[i] = 8'd0;
  endtask

  // Applies the inputs present at the clock edge that just occurred.
  task automatic model_update();
    bit       pop;
    evt_rec_t rec;
    logic [2:0] mk;
    logic [7:0] c;
    if (!reset) begin
      model_reset();
    end else if (clear) begin
      mq.delete();
      m_armed = 0;
      m_ovf   = 0;
      m_err   = 0;
      m_ts    = 0;
    end else begin
      pop = (mq.size() > 0) && evt_ready;
      mk  = 3'b000;
      if (sample_en && m_armed) begin
        for (int i = 0; i < 3; i++) begin
          c = count_in[i*8 +: 8];
          if (!((c == m_prev[i]) || (int'(c) == ((int'(m_prev[i]) + 1) % 256)))) mk[i] = 1'b1;
        end
      end
      if (pop) void'(mq.pop_front());
      if (mk != 3'b000) begin
        if (m_err < 65535) m_err++;
        if (mq.size() < DEPTH) begin
          rec.mask = mk;
          rec.snap = count_in;
          rec.ts   = 16'(m_ts);
          mq.push_back(rec);
        end else begin
          m_ovf = 1;
        end
      end
      if (sample_en) begin
        for (int i = 0; i < 3; i++) m_prev[i] = count_in[i*8 +: 8];
        m_armed = 1;
      end
      m_ts = (m_ts + 1) % 65536;
    end
  endtask

  task automatic compare_all();
    chk("evt_valid", evt_valid, (mq.size() > 0));
    if (mq.size() > 0) begin
      chk("evt_mask", evt_mask, mq[0].mask);
      chk("evt_snap", evt_snap, mq[0].snap);
      chk("evt_time", evt_time, mq[0].ts);
    end else begin
      chk("evt_mask_idle", evt_mask, 0);
      chk("evt_snap_idle", evt_snap, 0);
      chk("evt_time_idle", evt_time, 0);
    end
    chk("armed", armed, m_armed);
    chk("overflow", overflow, m_ovf);
    chk("err_total", err_total, m_err);
  endtask

  // Inputs are driven at the falling edge; outputs are checked at the next one.
  task automatic step(input bit en, input bit clr, input bit rdy, input logic [23:0] cin);
    sample_en = en;
    clear     = clr;
    evt_ready = rdy;
    count_in  = cin;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic reset_pulse();
    reset     = 1'b0;
    sample_en = 1'b0;
    clear     = 1'b0;
    evt_ready = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_async_valid", evt_valid, 0);
    chk("rst_async_armed", armed, 0);
    chk("rst_async_err", err_total, 0);
    chk("rst_async_time", evt_time, 0);
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
    reset = 1'b1;
  endtask

  initial begin
    int          seq [4];
    int          cur_ts;
    int          prev_ts;
    int          npop;
    logic [23:0] alt;
    logic [7:0]  last [3];
    logic [23:0] cin;
    int          r;

    reset     = 1'b0;
    sample_en = 1'b0;
    clear     = 1'b0;
    evt_ready = 1'b0;
    count_in  = '0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    reset = 1'b1;

    chk("reset_valid", evt_valid, 0);
    chk("reset_armed", armed, 0);
    chk("reset_overflow", overflow, 0);

    // legal sequence 0,1,2,2,3
    step(1, 0, 0, 24'h000000);
    chk("armed_after_first", armed, 1);
    seq = '{1, 2, 2, 3};
    for (int k = 0; k < 4; k++) step(1, 0, 0, {3{8'(seq[k])}});
    chk("legal_seq_valid", evt_valid, 0);
    chk("legal_seq_err", err_total, 0);

    // wrap 254 -> 255 -> 0 is legal
    step(0, 1, 0, 24'h0);
    chk("clear_disarms", armed, 0);
    step(1, 0, 0, 24'h0000FE);
    step(1, 0, 0, 24'h0000FF);
    step(1, 0, 0, 24'h000000);
    chk("wrap_valid", evt_valid, 0);
    chk("wrap_err", err_total, 0);

    // two counters jump in one sample
    step(0, 1, 0, 24'h0);
    step(1, 0, 0, 24'h050505);
    chk("pre_evt_valid", evt_valid, 0);
    step(1, 0, 0, 24'h050907);
    chk("evt_valid_lat1", evt_valid, 1);
    chk("evt_mask_011", evt_mask, 3'b011);
    chk("evt_snap_597", evt_snap, 24'h050907);
    chk("evt_err_1", err_total, 1);

    // nine violations with no pops overflow an eight-entry queue
    step(0, 1, 0, 24'h0);
    step(1, 0, 0, 24'h000000);
    alt = 24'h050505;
    for (int k = 0; k < 9; k++) begin
      step(1, 0, 0, alt);
      alt = (alt == 24'h050505) ? 24'h000000 : 24'h050505;
    end
    chk("ovf_err_9", err_total, 9);
    chk("ovf_sticky", overflow, 1);
    prev_ts = -1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_valid", evt_valid, 1);
      cur_ts = int'(evt_time);
      chk("drain_ts_increasing", (cur_ts > prev_ts), 1);
      prev_ts = cur_ts;
      step(0, 0, 1, alt);
    end
    chk("drained_empty", evt_valid, 0);

    // push and pop together on a full queue
    step(0, 1, 0, 24'h0);
    step(1, 0, 0, 24'h000000);
    alt = 24'h050505;
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 0, alt);
      alt = (alt == 24'h050505) ? 24'h000000 : 24'h050505;
    end
    chk("full_no_ovf", overflow, 0);
    step(1, 0, 1, alt);
    chk("pushpop_no_ovf", overflow, 0);
    chk("pushpop_err_9", err_total, 9);
    npop = 0;
    while (evt_valid && npop < 20) begin
      step(0, 0, 1, 24'h0);
      npop++;
    end
    chk("pushpop_occupancy", npop, 8);

    // clear wins over a simultaneous violation
    step(0, 1, 0, 24'h0);
    step(1, 0, 0, 24'h000000);
    step(1, 0, 0, 24'h050505);
    step(1, 0, 0, 24'h000000);
    step(1, 0, 0, 24'h050505);
    chk("three_queued_err", err_total, 3);
    step(1, 1, 0, 24'h000000);
    chk("clear_valid", evt_valid, 0);
    chk("clear_armed", armed, 0);
    chk("clear_err", err_total, 0);
    step(1, 0, 0, 24'h000000);
    step(1, 0, 0, 24'h050505);
    chk("pre_reset_valid", evt_valid, 1);
    reset_pulse();
    chk("post_reset_armed", armed, 0);
    chk("post_reset_err", err_total, 0);

    // random traffic, mostly legal steps
    for (int i = 0; i < 3; i++) last[i] = 8'd0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset_pulse();
      end else begin
        for (int i = 0; i < 3; i++) begin
          r = int'($urandom_range(0, 9));
          if (r < 4)      cin[i*8 +: 8] = last[i];
          else if (r < 8) cin[i*8 +: 8] = last[i] + 8'd1;
          else            cin[i*8 +: 8] = 8'($urandom_range(0, 255));
        end
        if ($urandom_range(0, 3) != 0) begin
          for (int i = 0; i < 3; i++) last[i] = cin[i*8 +: 8];
          step(1, ($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0), cin);
        end else begin
          step(0, ($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0), cin);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
